// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: 8 level requesters share one resource; the grant is held until the owner drops req.
// ARB_TIMEOUT_EN adds a MAX_HOLD-cycle hold limit with a one-cycle timeout pulse on forced revocation.
module rr_grant_arbiter #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            gnt_valid,
  output logic [2:0]      ptr,
  output logic            timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      win;
  logic            found;
  logic [2:0]      cand;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tout_q, tout_d;
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  // Rotating-priority search: first set bit starting at ptr, wrapping 7 -> 0.
  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    cand  = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_q + i[2:0];
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << win;
          idx_d   = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = 3'd0;
          ptr_d   = idx_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == 8'(MAX_HOLD - 1)) begin
          // Owner still requesting at the limit: revoke and move priority past it.
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = 3'd0;
          ptr_d   = idx_q + 3'd1;
          tout_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign ptr       = ptr_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = tout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
